// File: rtl/serial_magnitude_cmp_pkg.sv
// Shared types for the multi-cycle magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} cmp_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

endpackage

// File: rtl/serial_magnitude_cmp_chunk.sv
// One-chunk unsigned compare; flip_msb turns it into a signed compare of the top chunk.
module chunk_cmp #(
  parameter int CHUNK_BITS = 8
) (
  input  logic [CHUNK_BITS-1:0] a,
  input  logic [CHUNK_BITS-1:0] b,
  input  logic                  flip_msb,
  output logic                  eq,
  output logic                  lt
);

  localparam logic [CHUNK_BITS-1:0] MSB_MASK = CHUNK_BITS'(1) << (CHUNK_BITS - 1);

  logic [CHUNK_BITS-1:0] a_m, b_m;

  assign a_m = a ^ (flip_msb ? MSB_MASK : '0);
  assign b_m = b ^ (flip_msb ? MSB_MASK : '0);
  assign eq  = (a_m == b_m);
  assign lt  = (a_m < b_m);

endmodule

// File: rtl/serial_magnitude_cmp.sv
// Serial MSB-chunk-first magnitude comparator with valid/ready on both sides.
// Optional CMP_EARLY_EXIT_EN: leave CMP as soon as the first differing chunk is seen.
module serial_magnitude_cmp
  import cmp_pkg::*;
#(
  parameter int NUM_BITS   = 32,
  parameter int CHUNK_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] data1,
  input  logic [NUM_BITS-1:0] data2,
  input  logic                is_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                equal,
  output logic                not_equal,
  output logic                less_than,
  output logic                greater_than
);

  localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_CHUNKS - 1);
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  if ((NUM_BITS % CHUNK_BITS) != 0) begin : g_bad_chunk
    $error("CHUNK_BITS must divide NUM_BITS exactly");
  end

  cmp_state_t state_q, state_d;
  logic [NUM_CHUNKS-1:0][CHUNK_BITS-1:0] a_q, a_d, b_q, b_d;
  logic                                  sgn_q, sgn_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  // res.eq doubles as "not yet decided": it starts at 1 and clears on the first differing chunk.
  cmp_result_t                           res_q, res_d;

  logic c_eq, c_lt;

  chunk_cmp #(.CHUNK_BITS(CHUNK_BITS)) u_chunk (
    .a        (a_q[idx_q]),
    .b        (b_q[idx_q]),
    .flip_msb (sgn_q && (idx_q == TOP_IDX)),
    .eq       (c_eq),
    .lt       (c_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = data1;
          b_d     = data2;
          sgn_d   = is_signed;
          idx_d   = TOP_IDX;
          res_d   = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
          state_d = CMP;
        end
      end
      CMP: begin
        if (res_q.eq && !c_eq) begin
          res_d.eq = 1'b0;
          res_d.lt = c_lt;
          res_d.gt = !c_lt;
        end
        idx_d = idx_q - 1'b1;
        if ((idx_q == '0) || (EARLY_EXIT && !c_eq)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign out_valid    = (state_q == DONE);
  assign equal        = out_valid && res_q.eq;
  assign not_equal    = out_valid && !res_q.eq;
  assign less_than    = out_valid && res_q.lt;
  assign greater_than = out_valid && res_q.gt;

endmodule

// File: tb/tb_serial_magnitude_cmp.sv
// Directed bench: 32/8 comparator (dut0) and single-chunk 32/32 comparator (dut1).
module tb_serial_magnitude_cmp;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int NC = 4;
  localparam logic [3:0] R_EQ = 4'b1000;  // {eq, ne, lt, gt}
  localparam logic [3:0] R_LT = 4'b0110;
  localparam logic [3:0] R_GT = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, is_signed, out_ready, sel;
  logic [31:0] data1, data2;
  logic        ir0, ov0, eq0, ne0, lt0, gt0;
  logic        ir1, ov1, eq1, ne1, lt1, gt1;
  logic        in_ready, out_valid;
  logic [3:0]  res;
  int vectors = 0;
  int errs    = 0;

  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign res       = sel ? {eq1, ne1, lt1, gt1} : {eq0, ne0, lt0, gt0};

  serial_magnitude_cmp #(.NUM_BITS(32), .CHUNK_BITS(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ir0),
    .data1(data1), .data2(data2), .is_signed(is_signed),
    .out_valid(ov0), .out_ready(out_ready && !sel),
    .equal(eq0), .not_equal(ne0), .less_than(lt0), .greater_than(gt0));

  serial_magnitude_cmp #(.NUM_BITS(32), .CHUNK_BITS(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(ir1),
    .data1(data1), .data2(data2), .is_signed(is_signed),
    .out_valid(ov1), .out_ready(out_ready && sel),
    .equal(eq1), .not_equal(ne1), .less_than(lt1), .greater_than(gt1));

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int lat, input logic [3:0] exp, input int hold, input string nm);
    int w;
    @(negedge clk);
    data1 = a; data2 = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL %s accept: in_ready=%b required 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; data1 = ~a; data2 = ~b; is_signed = ~s;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        vectors++;
        if (out_valid !== 1'b0 || res !== 4'b0) begin
          errs++; $display("FAIL %s early cycle %0d: out_valid=%b res=%b required 0/0000", nm, k, out_valid, res);
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL %s latency %0d: out_valid=%b in_ready=%b required 1/0", nm, lat, out_valid, in_ready);
    end
    vectors++;
    if (res !== exp) begin
      errs++; $display("FAIL %s result: got %b required %b", nm, res, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || res !== exp || in_ready !== 1'b0) begin
        errs++; $display("FAIL %s hold %0d: ov=%b res=%b ir=%b required 1/%b/0", nm, h, out_valid, res, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 4'b0) begin
      errs++; $display("FAIL %s after handshake: ov=%b ir=%b res=%b required 0/1/0000", nm, out_valid, in_ready, res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    data1 = '0; data2 = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ir0, ov0, eq0, ne0, lt0, gt0, ir1, ov1} !== 8'b0) begin
      errs++; $display("FAIL reset outputs: got %b required 00000000", {ir0, ov0, eq0, ne0, lt0, gt0, ir1, ov1});
    end
    rst = 1'b0; #1;
    vectors++;
    if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
      errs++; $display("FAIL reset release in_ready: got %b%b required 11", ir0, ir1);
    end
  endtask

  task automatic test_equal();
    run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5, R_EQ, 0, "eq_unsigned");
    run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5, R_EQ, 0, "eq_signed");
  endtask

  task automatic test_sign_mode();
    run_op(32'h80000000, 32'h00000001, 1'b0, EARLY ? 2 : 5, R_GT, 0, "msb_unsigned");
    run_op(32'h80000000, 32'h00000001, 1'b1, EARLY ? 2 : 5, R_LT, 0, "msb_signed");
    run_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 5, R_LT, 0, "neg_signed");
  endtask

  task automatic test_backpressure();
    run_op(32'h12345678, 32'h12345679, 1'b0, 5, R_LT, 3, "hold_lt");
    run_op(32'h01000000, 32'h02000000, 1'b0, EARLY ? 2 : 5, R_LT, 0, "top_chunk_lt");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data1 = 32'h00000009; data2 = 32'h00000001; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ov0 !== 1'b0 || {eq0, ne0, lt0, gt0} !== 4'b0 || ir0 !== 1'b0) begin
      errs++; $display("FAIL rst_mid abort: ov=%b res=%b ir=%b required 0/0000/0", ov0, {eq0, ne0, lt0, gt0}, ir0);
    end
    rst = 1'b0; #1;
    vectors++;
    if (ir0 !== 1'b1) begin
      errs++; $display("FAIL rst_mid idle: in_ready=%b required 1", ir0);
    end
    run_op(32'h00000100, 32'h000000FF, 1'b0, EARLY ? 4 : 5, R_GT, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int n, ov_cnt;
    logic [3:0] first_res;
    first_res = 4'b0; ov_cnt = 0;
    @(negedge clk);
    sel = 1'b0; data1 = 32'h55AA55AA; data2 = 32'h55AA55AA; is_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    data1 = 32'h00000005; data2 = 32'h00000003;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin ov_cnt++; first_res = res; end
      if (in_ready) break;
    end
    vectors++;
    if (n !== NC + 2) begin
      errs++; $display("FAIL b2b interval: got %0d required %0d", n, NC + 2);
    end
    vectors++;
    if (ov_cnt !== 1 || first_res !== R_EQ) begin
      errs++; $display("FAIL b2b first: out_valid cycles=%0d res=%b required 1/%b", ov_cnt, first_res, R_EQ);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; data1 = '0; data2 = 32'hFFFFFFFF;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    vectors++;
    if (n !== 5 || res !== R_GT) begin
      errs++; $display("FAIL b2b second: latency=%0d res=%b required 5/%b", n, res, R_GT);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL b2b single-cycle valid: out_valid=%b required 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single_chunk();
    sel = 1'b1;
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 2, R_LT, 0, "nc1_signed");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 2, R_GT, 1, "nc1_unsigned");
    run_op(32'h80000000, 32'h80000000, 1'b1, 2, R_EQ, 0, "nc1_equal");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_sign_mode();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_single_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
